// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide over 32 cycles.
// Optional macro MDU_FAST_MULT_EN: when defined, MULT/MULTU complete in a single cycle.
module mult_div_unit (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Start_E,
  input  logic [1:0]  Op_E,
  input  logic [31:0] Operand1_E,
  input  logic [31:0] Operand2_E,
  input  logic        HiLoRead_E,
  input  logic        WriteHI_E,
  input  logic        WriteLO_E,
  input  logic [31:0] WriteData_E,
  output logic [31:0] HI_Out,
  output logic [31:0] LO_Out,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic        DivZero
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [5:0]  count_r;
  logic        is_div_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic [31:0] opnd_r;
  logic [63:0] acc_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;
  logic        divzero_r;

  logic        is_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        div_zero_s;

  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic [63:0] div_next_s;
  logic [63:0] step_next_s;
  logic [63:0] prod_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // Operand magnitudes and signs; only signed ops (Op_E[0]==0) honour bit 31.
  assign is_signed_s = ~Op_E[0];
  assign a_neg_s     = is_signed_s & Operand1_E[31];
  assign b_neg_s     = is_signed_s & Operand2_E[31];
  assign mag_a_s     = a_neg_s ? (32'd0 - Operand1_E) : Operand1_E;
  assign mag_b_s     = b_neg_s ? (32'd0 - Operand2_E) : Operand2_E;
  assign div_zero_s  = Op_E[1] & (Operand2_E == 32'd0);

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_mag_s;
  logic [63:0] fast_prod_s;

  assign fast_mag_s  = {32'd0, mag_a_s} * {32'd0, mag_b_s};
  assign fast_prod_s = (a_neg_s ^ b_neg_s) ? (64'd0 - fast_mag_s) : fast_mag_s;
`endif

  // One radix-2 step on acc_r: {HI,LO} accumulator for multiply, {remainder,quotient} for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    mul_next_s  = {mul_sum_s, acc_r[31:1]};
    div_shift_s = acc_r[63:31];
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    div_next_s  = 64'd0;
    step_next_s = 64'd0;
    prod_s      = 64'd0;
    res_hi_s    = 32'd0;
    res_lo_s    = 32'd0;
    // Shifted remainder is below 2*divisor, so bit 32 of the difference is a clean borrow.
    if (div_diff_s[32]) begin
      div_next_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
    end
    if (is_div_r) begin
      step_next_s = div_next_s;
      res_lo_s    = neg_q_r ? (32'd0 - div_next_s[31:0])  : div_next_s[31:0];
      res_hi_s    = neg_r_r ? (32'd0 - div_next_s[63:32]) : div_next_s[63:32];
    end else begin
      step_next_s = mul_next_s;
      prod_s      = neg_q_r ? (64'd0 - mul_next_s) : mul_next_s;
      res_hi_s    = prod_s[63:32];
      res_lo_s    = prod_s[31:0];
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= ST_IDLE;
      count_r   <= 6'd0;
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      opnd_r    <= 32'd0;
      acc_r     <= 64'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          count_r <= 6'd0;
          if (Start_E) begin
            if (div_zero_s) begin
              done_r    <= 1'b1;
              divzero_r <= 1'b1;
            end
`ifdef MDU_FAST_MULT_EN
            else if (!Op_E[1]) begin
              hi_r   <= fast_prod_s[63:32];
              lo_r   <= fast_prod_s[31:0];
              done_r <= 1'b1;
            end
`endif
            else begin
              // Divide iterates on the dividend, multiply on the multiplier.
              is_div_r <= Op_E[1];
              neg_q_r  <= a_neg_s ^ b_neg_s;
              neg_r_r  <= a_neg_s;
              opnd_r   <= Op_E[1] ? mag_b_s : mag_a_s;
              acc_r    <= Op_E[1] ? {32'd0, mag_a_s} : {32'd0, mag_b_s};
              state_r  <= ST_RUN;
            end
          end else begin
            if (WriteHI_E) begin
              hi_r <= WriteData_E;
            end else begin
              hi_r <= hi_r;
            end
            if (WriteLO_E) begin
              lo_r <= WriteData_E;
            end else begin
              lo_r <= lo_r;
            end
          end
        end
        ST_RUN: begin
          acc_r <= step_next_s;
          if (count_r == 6'd31) begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            done_r  <= 1'b1;
            count_r <= 6'd0;
            state_r <= ST_IDLE;
          end else begin
            count_r <= count_r + 6'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= 6'd0;
        end
      endcase
    end
  end

  assign Busy    = (state_r == ST_RUN);
  assign Stall   = Busy & (Start_E | HiLoRead_E | WriteHI_E | WriteLO_E);
  assign HI_Out  = hi_r;
  assign LO_Out  = lo_r;
  assign Done    = done_r;
  assign DivZero = divzero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
// Honours MDU_FAST_MULT_EN when the same macro is defined for the bench.
module tb_mult_div_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Start_E;
  logic [1:0]  Op_E;
  logic [31:0] Operand1_E;
  logic [31:0] Operand2_E;
  logic        HiLoRead_E;
  logic        WriteHI_E;
  logic        WriteLO_E;
  logic [31:0] WriteData_E;
  logic [31:0] HI_Out;
  logic [31:0] LO_Out;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic        DivZero;

`ifdef MDU_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .CLOCK(CLOCK), .RESET(RESET), .Start_E(Start_E), .Op_E(Op_E),
    .Operand1_E(Operand1_E), .Operand2_E(Operand2_E), .HiLoRead_E(HiLoRead_E),
    .WriteHI_E(WriteHI_E), .WriteLO_E(WriteLO_E), .WriteData_E(WriteData_E),
    .HI_Out(HI_Out), .LO_Out(LO_Out), .Busy(Busy), .Stall(Stall),
    .Done(Done), .DivZero(DivZero)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_inputs();
    Start_E = 1'b0; Op_E = 2'b00; Operand1_E = 32'd0; Operand2_E = 32'd0;
    HiLoRead_E = 1'b0; WriteHI_E = 1'b0; WriteLO_E = 1'b0; WriteData_E = 32'd0;
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: ref_result = sa * sb;
      2'b01: ref_result = {32'd0, a} * {32'd0, b};
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        ref_result = {rv[31:0], qv[31:0]};
      end
      default: ref_result = {a % b, a / b};
    endcase
  endfunction

  task automatic write_hilo(input bit h, input bit l, input logic [31:0] d);
    WriteHI_E = h; WriteLO_E = l; WriteData_E = d;
    tick();
    clear_inputs();
    if (h) m_hi = d;
    if (l) m_lo = d;
    chk("mthi_mtlo", {HI_Out, LO_Out}, {m_hi, m_lo});
    chk("mt_no_done", 64'(Done), 64'd0);
  endtask

  // Issue one operation, then inject random stall-causing noise while it is expected to be busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_wr);
    logic [63:0] exp;
    bit          dz, iter, eb, es;
    int          lat;
    dz   = op[1] && (b == 32'd0);
    iter = op[1] ? !dz : !FAST;
    exp  = dz ? {m_hi, m_lo} : ref_result(op, a, b);
    Start_E = 1'b1; Op_E = op; Operand1_E = a; Operand2_E = b;
    if (with_wr) begin
      WriteHI_E = 1'b1; WriteLO_E = 1'b1; WriteData_E = $urandom;
    end
    tick();
    clear_inputs();
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) begin
        lat = i;
        break;
      end
      eb = iter && (i < 32);
      chk("busy", 64'(Busy), 64'(eb));
      chk("hold_hilo", {HI_Out, LO_Out}, {m_hi, m_lo});
      Start_E = 1'($urandom); HiLoRead_E = 1'($urandom);
      WriteHI_E = 1'($urandom); WriteLO_E = 1'($urandom);
      Op_E = 2'($urandom); Operand1_E = $urandom; Operand2_E = $urandom; WriteData_E = $urandom;
      #1;
      es = eb & (Start_E | HiLoRead_E | WriteHI_E | WriteLO_E);
      chk("stall", 64'(Stall), 64'(es));
      tick();
    end
    clear_inputs();
    chk("done_latency", 64'(lat), iter ? 64'd32 : 64'd0);
    chk("result_hilo", {HI_Out, LO_Out}, exp);
    chk("divzero", 64'(DivZero), 64'(dz));
    chk("busy_at_done", 64'(Busy), 64'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    tick();
    chk("done_one_cycle", 64'(Done), 64'd0);
    chk("divzero_one_cycle", 64'(DivZero), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'd0; corners[1] = 32'd1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) pick_operand = corners[$urandom_range(4)];
    else pick_operand = $urandom;
  endfunction

  initial begin
    RESET = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk("reset_hilo", {HI_Out, LO_Out}, 64'd0);
    chk("reset_flags", {60'd0, Busy, Stall, Done, DivZero}, 64'd0);
    RESET = 1'b1;

    // Directed cases with literal expectations.
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("mult_7_m3", {HI_Out, LO_Out}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    chk("divu_100_7", {HI_Out, LO_Out}, {32'd2, 32'd14});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_m7_2", {HI_Out, LO_Out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_overflow", {HI_Out, LO_Out}, {32'd0, 32'h8000_0000});
    write_hilo(1'b1, 1'b1, 32'h1234_5678);
    run_op(2'b10, 32'd5, 32'd0, 1'b0);
    chk("div_by_zero_keep", {HI_Out, LO_Out}, {32'h1234_5678, 32'h1234_5678});
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_ffff_2", {HI_Out, LO_Out}, {32'd1, 32'hFFFF_FFFE});
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    write_hilo(1'b1, 1'b0, 32'hCAFE_0001);
    write_hilo(1'b0, 1'b1, 32'hCAFE_0002);

    // Randomized mix of operations and MTHI/MTLO writes.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(5) == 0) begin
        write_hilo(1'($urandom), 1'($urandom), $urandom);
      end else if ($urandom_range(7) == 0) begin
        run_op(2'($urandom_range(2, 3)), pick_operand(), 32'd0, 1'($urandom));
      end else begin
        run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom));
      end
    end

    // Reset in the middle of a multiply: immediate clear, no Done afterwards.
    write_hilo(1'b1, 1'b1, 32'h5555_AAAA);
    Start_E = 1'b1; Op_E = 2'b00; Operand1_E = 32'd123; Operand2_E = 32'd456;
    tick();
    clear_inputs();
    repeat (9) tick();
    HiLoRead_E = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    chk("async_reset_hilo", {HI_Out, LO_Out}, 64'd0);
    chk("async_reset_flags", {60'd0, Busy, Stall, Done, DivZero}, 64'd0);
    HiLoRead_E = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    RESET = 1'b1;
    for (int i = 0; i < 35; i++) begin
      chk("no_done_after_abort", {62'd0, Done, Busy}, 64'd0);
      tick();
    end
    chk("post_abort_hilo", {HI_Out, LO_Out}, 64'd0);

    // First Start right after reset release is taken on the first edge.
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    run_op(2'b11, 32'd1000, 32'd33, 1'b0);
    chk("divu_after_reset", {HI_Out, LO_Out}, {32'd10, 32'd30});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
